// File: rtl/dm_port_arbiter_if.sv
// rtl/dm_port_arbiter_if.sv - requester and memory-side signal bundle for the data-memory port arbiter
interface dm_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  // Arbiter side: consumes requests and memory read data, produces grants and memory drive.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rd,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_we, mem_addr, mem_wd
  );

  // Environment side: the two requesters plus the memory returning read data.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rd,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - two-port data-memory arbiter with bounded bursts; ARB_RR_EN selects round-robin tie-break
module dm_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  dm_port_arbiter_if.slave bus
);
  localparam int             CW      = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;

`ifdef ARB_RR_EN
  logic last;
`endif

  // Grant the owner only while it still requests, and steer its address/data onto the memory port.
  always_comb begin
    gnt0     = (state == OWN0) & bus.req0;
    gnt1     = (state == OWN1) & bus.req1;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (gnt0) begin
      mem_we   = bus.we0;
      mem_addr = bus.addr0;
      mem_wd   = bus.wdata0;
    end else if (gnt1) begin
      mem_we   = bus.we1;
      mem_addr = bus.addr1;
      mem_wd   = bus.wdata1;
    end
  end

  // Ownership next-state: hand over when the owner releases or its burst budget runs out under contention.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
`ifdef ARB_RR_EN
        if (bus.req0 && bus.req1) state_nxt = last ? OWN0 : OWN1;
        else if (bus.req0)        state_nxt = OWN0;
        else if (bus.req1)        state_nxt = OWN1;
`else
        if (bus.req0)      state_nxt = OWN0;
        else if (bus.req1) state_nxt = OWN1;
`endif
      end
      OWN0: begin
        if (!bus.req0) begin
          state_nxt     = bus.req1 ? OWN1 : IDLE;
          burst_cnt_nxt = '0;
        end else if (bus.req1) begin
          if (burst_cnt == CNT_MAX) begin
            state_nxt     = OWN1;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + 1'b1;
          end
        end else begin
          burst_cnt_nxt = '0;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_nxt     = bus.req0 ? OWN0 : IDLE;
          burst_cnt_nxt = '0;
        end else if (bus.req0) begin
          if (burst_cnt == CNT_MAX) begin
            state_nxt     = OWN0;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + 1'b1;
          end
        end else begin
          burst_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // State register and one-cycle read return; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      rvalid0   <= gnt0 & ~bus.we0;
      rvalid1   <= gnt1 & ~bus.we1;
      if (gnt0 && !bus.we0) rdata0 <= bus.mem_rd;
      if (gnt1 && !bus.we1) rdata1 <= bus.mem_rd;
    end
  end

`ifdef ARB_RR_EN
  // Remember which port was served most recently to break IDLE ties toward the other one.
  always_ff @(posedge clk) begin
    if (!rst_n)    last <= 1'b1;
    else if (gnt0) last <= 1'b0;
    else if (gnt1) last <= 1'b1;
  end
`endif

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rvalid0  = rvalid0;
  assign bus.rvalid1  = rvalid1;
  assign bus.rdata0   = rdata0;
  assign bus.rdata1   = rdata1;
  assign bus.mem_we   = mem_we;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wd   = mem_wd;
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory/MMU port between two requesters: port 0 (CPU load/store path) and port 1 (UART program loader / DMA-style writer).
- Sits between the requesters and the memory subsystem's address_virtual/writeData/WE/readData interface.
- Registered ownership FSM with a bounded burst length, so neither requester starves the other.
- Returns read data with a fixed 1-cycle latency per granted access.

Parameters:
- AW, 16, address width (matches the 16-bit virtual address)
- DW, 32, data width
- MAX_BURST, 4, maximum consecutive grants to one owner while the other port is requesting (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous reset, active low
- req0  in  1  port 0 access request, held until gnt0
- we0  in  1  port 0 write enable (1=store, 0=load)
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- gnt0  out  1  port 0 access performed this cycle
- rvalid0  out  1  port 0 read data valid (cycle after a granted read)
- rdata0  out  DW  port 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_we  out  1  to memory WE
- mem_addr  out  AW  to memory address_virtual
- mem_wd  out  DW  to memory writeData
- mem_rd  in  DW  combinational read data from memory

Behaviour:
- Clocking/reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, burst_cnt=0, last=1
  - rvalid0/1=0, rdata0/1=0
  - gnt0/1=0, mem_we=0, mem_addr=0, mem_wd=0
- Reset mid-burst aborts the burst. An in-flight rvalid is dropped.
- States: IDLE, OWN0, OWN1.
- Grant (combinational):
  - gnt_k = (state==OWNk) & req_k.
  - When gnt_k=1: mem_addr=addr_k, mem_wd=wdata_k, mem_we=we_k.
  - With no grant: mem_we=0, mem_addr=0, mem_wd=0.
  - gnt0 and gnt1 are never both 1.
- Read return:
  - At the edge ending a cycle with gnt_k & ~we_k: rdata_k <= mem_rd and rvalid_k <= 1.
  - Otherwise rvalid_k <= 0 and rdata_k holds its value.
  - Writes produce no rvalid.
- IDLE transitions:
  - req0 -> OWN0
  - else req1 -> OWN1
  - else stay IDLE
  - Arbitration costs one cycle: the first grant occurs the cycle after req rises from IDLE.
- OWNk transitions (o = other port):
  - req_k=0: req_o -> OWNo, else IDLE; burst_cnt<=0.
  - req_k=1, req_o=1, burst_cnt==MAX_BURST-1: -> OWNo, burst_cnt<=0. This is a handover with no bubble; the other port is granted the next cycle.
  - req_k=1 otherwise: stay in OWNk. burst_cnt<=burst_cnt+1, saturating at MAX_BURST-1. The counter advances only while req_o=1; it resets to 0 when req_o=0.
- last <= k whenever gnt_k=1.
- Width rules:
  - burst_cnt width is $clog2(MAX_BURST)+1.
  - With MAX_BURST=1, ownership alternates every cycle while both ports request.
- Boundary conditions:
  - req_k dropped in the same cycle the handover condition is met: the req_k=0 rule applies (same result).
  - Address/data from the non-owner are ignored entirely.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: in IDLE with req0 & req1 both 1, go to OWN(1-last), i.e. the port not served most recently. Since last resets to 1, port 0 wins first after reset.
- Undefined: fixed priority, with port 0 winning in IDLE. The `last` register and its logic are removed.
- The burst limit applies in both builds.

Test Plan:
- Reset, then read: hold rst_n=0 for 2 cycles -> all outputs 0. Release, req0=1, we0=0, addr0=0x0010, mem_rd=0xDEADBEEF -> gnt0 on cycle 2, rvalid0=1 and rdata0=0xDEADBEEF on cycle 3.
- Port 1 write: req1=1, we1=1, addr1=0x0100, wdata1=0x12345678 -> mem_we=1, mem_addr=0x0100, mem_wd=0x12345678 in the gnt1 cycle; rvalid1 stays 0.
- Contention, MAX_BURST=4: req0 and req1 held high from IDLE -> grant pattern 0,0,0,0,1,1,1,1,0... with no idle cycles between owners.
- Release mid-burst: OWN0 after 2 grants, req0 drops while req1=1 -> gnt1 on the next cycle and burst_cnt=0.
- Reset mid-operation: rst_n=0 during OWN1 while a read is pending -> next cycle state=IDLE, rvalid1=0, gnt1=0.
- Both builds, IDLE with simultaneous req0/req1 after a port-0 access: with ARB_RR_EN -> port 1 granted first; without -> port 0 granted first.
